fetch_prefetch: RTL and testbench

Parametrised successor to the single-register fetch stage of the rv32i pipeline. It keeps up to `DEPTH` requests in flight on the instruction memory port (valid/grant request, in-order response). It buffers returned words with their PCs in a prefetch FIFO and presents one instruction per cycle to decode with stall back-pressure. It also supports pipeline redirects (branch/jump), which flush all buffered and in-flight fetches.

---
 rtl/fetch_prefetch.sv | 118 +++++++++++
 tb/tb_fetch_prefetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage with a prefetch FIFO and up to DEPTH in-flight memory requests.
// Responses return in order. Redirects flush the FIFO and mark in-flight words to be dropped.
module fetch_prefetch #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ILEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'('h10),
  parameter int unsigned DEPTH         = 4,
  localparam int unsigned LW           = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            clr_n,
  output logic            mio_req,
  output logic [XLEN-1:0] mio_addr,
  input  logic            mio_gnt,
  input  logic            mio_vld,
  input  logic [ILEN-1:0] mio_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            pen,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic [ILEN-1:0] instr,
  output logic [LW-1:0]   level
);

  localparam int unsigned AW = LW - 1;
  localparam int unsigned CW = LW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   outst_q, outst_d;
  logic [LW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [ILEN-1:0] ins_mem_q [DEPTH];

  logic [LW-1:0]   level_c;
  logic [CW-1:0]   inflight_c;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [XLEN-1:0] redirect_base;
  logic [XLEN-1:0] head_pc;
  logic            grant, push, pop;

  assign level_c       = wr_ptr_q - rd_ptr_q;
  assign inflight_c    = CW'(level_c) + CW'(outst_q);
  assign wr_idx        = wr_ptr_q[AW-1:0];
  assign rd_idx        = rd_ptr_q[AW-1:0];
  assign redirect_base = redirect_pc & ~(XLEN'(3));

  // Credit check uses pre-pop occupancy; no request while resetting or redirecting.
  assign mio_req  = clr_n & ~redirect & (inflight_c < CW'(DEPTH));
  assign mio_addr = fetch_pc_q;
  assign grant    = mio_req & mio_gnt;
  assign push     = mio_vld & ~redirect & (discard_q == '0);
  assign pop      = pen & ~stall & ~redirect;

  // Presented instruction comes straight from the FIFO head; zeroed when empty.
  assign head_pc = pc_mem_q[rd_idx];
  assign level   = level_c;
  assign pen     = (level_c != '0);
  assign pc      = pen ? head_pc : '0;
  assign next_pc = pen ? head_pc + XLEN'(4) : '0;
  assign instr   = pen ? ins_mem_q[rd_idx] : '0;

  // Next-state for fetch address, response PC, FIFO pointers and in-flight counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    discard_d  = discard_q;
    outst_d    = outst_q + LW'(grant) - LW'(mio_vld);
    if (redirect) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      rd_ptr_d   = wr_ptr_q;
      discard_d  = outst_q - LW'(mio_vld);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) begin
        wr_ptr_d = wr_ptr_q + LW'(1);
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + LW'(1);
      if (mio_vld && (discard_q != '0)) discard_d = discard_q - LW'(1);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // FIFO storage; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_idx]  <= rsp_pc_q;
      ins_mem_q[wr_idx] <= mio_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a 1-cycle in-order memory returning rdata = addr.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        mio_req;
  logic [31:0] mio_addr;
  logic        mio_gnt;
  logic        mio_vld;
  logic [31:0] mio_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        pen;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic [31:0] mq [64];
  logic [5:0]  mh = '0;
  logic [5:0]  mt = '0;

  fetch_prefetch #(.XLEN(32), .ILEN(32), .RESET_PC(32'h10), .DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .mio_req(mio_req), .mio_addr(mio_addr), .mio_gnt(mio_gnt),
    .mio_vld(mio_vld), .mio_rdata(mio_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .pen(pen), .pc(pc), .next_pc(next_pc), .instr(instr), .level(level)
  );

  always #5 clk = ~clk;

  // Memory model: queue of granted addresses, answered in order the cycle after grant.
  assign mio_gnt   = gnt_en;
  assign mio_vld   = rsp_en && (mh != mt);
  assign mio_rdata = mq[mh];

  always @(posedge clk) begin
    if (!clr_n) begin
      mh <= '0;
      mt <= '0;
    end else begin
      if (mio_vld) mh <= mh + 6'd1;
      if (mio_req && mio_gnt) begin
        mq[mt] <= mio_addr;
        mt     <= mt + 6'd1;
      end
    end
  end

  // A response must never arrive with nothing outstanding.
  always @(posedge clk) begin
    if (clr_n && mio_vld && dut.outst_q == '0) begin
      errors++;
      $display("FAIL vld_without_outstanding");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    clr_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    gnt_en = 1'b1; rsp_en = 1'b1;
    @(posedge clk); #1; @(posedge clk); #2;
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL reset_pen got %0b exp 0", pen); end
    checks++; if (mio_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", mio_req); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if ({pc, next_pc, instr} !== 96'd0) begin errors++; $display("FAIL reset_outs got %h %h %h exp 0", pc, next_pc, instr); end
  endtask

  task automatic test_stream();
    clr_n = 1'b1; #1;
    checks++; if (mio_req !== 1'b1 || mio_addr !== 32'h10) begin errors++; $display("FAIL stream_first_req got %0b %h exp 1 00000010", mio_req, mio_addr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b0 || mio_addr !== 32'h14) begin errors++; $display("FAIL stream_c1 got pen %0b addr %h exp 0 00000014", pen, mio_addr); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      checks++;
      if (pen !== 1'b1 || pc !== 32'h10 + 32'(4*k) || instr !== 32'h10 + 32'(4*k) ||
          next_pc !== 32'h14 + 32'(4*k) || level !== 3'd1) begin
        errors++;
        $display("FAIL stream_k%0d got pen %0b pc %h np %h instr %h lvl %0d exp pc %h",
                 k, pen, pc, next_pc, instr, level, 32'h10 + 32'(4*k));
      end
    end
  endtask

  task automatic test_stall();
    @(posedge clk); #1; stall = 1'b1; #1;
    checks++; if (pen !== 1'b1 || pc !== 32'h30) begin errors++; $display("FAIL stall_start got pen %0b pc %h exp 1 00000030", pen, pc); end
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #2;
      checks++; if (pen !== 1'b1 || pc !== 32'h30) begin errors++; $display("FAIL stall_hold_%0d got pen %0b pc %h exp 1 00000030", i, pen, pc); end
      if (i >= 3) begin
        checks++; if (level !== 3'd4 || mio_req !== 1'b0) begin errors++; $display("FAIL stall_full_%0d got lvl %0d req %0b exp 4 0", i, level, mio_req); end
      end
    end
    @(posedge clk); #1; stall = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (pen !== 1'b1 || pc !== 32'h30 + 32'(4*k)) begin errors++; $display("FAIL stall_resume_%0d got pen %0b pc %h exp 1 %h", k, pen, pc, 32'h30 + 32'(4*k)); end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_redirect();
    @(posedge clk); #1; clr_n = 1'b0;
    @(posedge clk); #1; clr_n = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0; #1;
    checks++; if (mio_addr !== 32'h10) begin errors++; $display("FAIL redir_c0 got %h exp 00000010", mio_addr); end
    @(posedge clk); #1; gnt_en = 1'b0; #1;
    @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h203; rsp_en = 1'b1; #1;
    checks++; if (mio_req !== 1'b0) begin errors++; $display("FAIL redir_req got %0b exp 0", mio_req); end
    @(posedge clk); #1; redirect = 1'b0; gnt_en = 1'b1; #1;
    checks++; if (pen !== 1'b0 || mio_req !== 1'b1 || mio_addr !== 32'h200) begin errors++; $display("FAIL redir_r1 got pen %0b req %0b addr %h exp 0 1 00000200", pen, mio_req, mio_addr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b0 || mio_addr !== 32'h204) begin errors++; $display("FAIL redir_r2 got pen %0b addr %h exp 0 00000204", pen, mio_addr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'h200 || instr !== 32'h200 || next_pc !== 32'h204) begin errors++; $display("FAIL redir_r3 got pen %0b pc %h instr %h np %h exp 1 200 200 204", pen, pc, instr, next_pc); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'h204) begin errors++; $display("FAIL redir_r4 got pen %0b pc %h exp 1 00000204", pen, pc); end
  endtask

  task automatic test_gnt_hold();
    @(posedge clk); #1; clr_n = 1'b0;
    @(posedge clk); #1; clr_n = 1'b1; gnt_en = 1'b0; rsp_en = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mio_req !== 1'b1 || mio_addr !== 32'h10 || pen !== 1'b0) begin errors++; $display("FAIL gnt_hold_%0d got req %0b addr %h pen %0b exp 1 00000010 0", i, mio_req, mio_addr, pen); end
      @(posedge clk); #2;
    end
    gnt_en = 1'b1; #1;
    checks++; if (mio_addr !== 32'h10) begin errors++; $display("FAIL gnt_grant got %h exp 00000010", mio_addr); end
    @(posedge clk); #2;
    checks++; if (mio_addr !== 32'h14) begin errors++; $display("FAIL gnt_adv got %h exp 00000014", mio_addr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'h10) begin errors++; $display("FAIL gnt_pen got pen %0b pc %h exp 1 00000010", pen, pc); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'h14) begin errors++; $display("FAIL gnt_pen2 got pen %0b pc %h exp 1 00000014", pen, pc); end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    checks++; if (mio_req !== 1'b0) begin errors++; $display("FAIL wrap_req got %0b exp 0", mio_req); end
    @(posedge clk); #1; redirect = 1'b0; #1;
    checks++; if (pen !== 1'b0 || mio_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_r1 got pen %0b addr %h exp 0 fffffffc", pen, mio_addr); end
    @(posedge clk); #2;
    checks++; if (mio_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", mio_addr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'hFFFF_FFFC || next_pc !== 32'h0 || instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_r3 got pen %0b pc %h np %h instr %h exp 1 fffffffc 0 fffffffc", pen, pc, next_pc, instr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'h0 || next_pc !== 32'h4 || instr !== 32'h0) begin errors++; $display("FAIL wrap_r4 got pen %0b pc %h np %h instr %h exp 1 0 4 0", pen, pc, next_pc, instr); end
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1; stall = 1'b1; rsp_en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++; if (level !== 3'd1 || mio_req !== 1'b0) begin errors++; $display("FAIL inflight_full got lvl %0d req %0b exp 1 0", level, mio_req); end
    @(posedge clk); #1; clr_n = 1'b0; stall = 1'b0; rsp_en = 1'b1; #1;
    checks++; if (mio_req !== 1'b0) begin errors++; $display("FAIL inflight_req_in_reset got %0b exp 0", mio_req); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL inflight_after_reset got pen %0b lvl %0d exp 0 0", pen, level); end
    clr_n = 1'b1; #1;
    checks++; if (mio_req !== 1'b1 || mio_addr !== 32'h10) begin errors++; $display("FAIL inflight_restart got req %0b addr %h exp 1 00000010", mio_req, mio_addr); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL inflight_c1 got pen %0b exp 0", pen); end
    @(posedge clk); #2;
    checks++; if (pen !== 1'b1 || pc !== 32'h10 || instr !== 32'h10) begin errors++; $display("FAIL inflight_c2 got pen %0b pc %h instr %h exp 1 10 10", pen, pc, instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_gnt_hold();
    test_wrap();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
